imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 19 +
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StChk,
    StDone,
    StErr
  } ld_state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = 2;
  localparam int unsigned HDR_N_W        = 8 * HDR_BYTES;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the core in reset.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Start,
  input  logic [7:0]             Byte_In,
  input  logic                   Byte_Valid,
  output logic                   Byte_Ready,
  output logic                   IMEM_WE,
  output logic [ADDR_WIDTH-1:0]  IMEM_Addr,
  output logic [INSTR_WIDTH-1:0] IMEM_WData,
  output logic                   CPU_Hold,
  output logic                   Load_Done,
  output logic                   Load_Err
);

  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam logic [HDR_N_W:0] MAX_WORDS = (HDR_N_W+1)'(2 ** ADDR_WIDTH);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  ld_state_e state_q, state_d;
  logic [HDR_N_W-1:0]     n_q, n_d;
  logic [23:0]            sr_q, sr_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             xor_q, xor_d;
`endif

  logic                   accept;
  logic [HDR_N_W-1:0]     n_full;
  logic                   last_word;

  assign Byte_Ready = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                      (state_q == StData)  || (state_q == StChk);
  assign accept     = Byte_Valid & Byte_Ready;
  assign n_full     = {n_q[HDR_N_W-1:8], Byte_In};
  // Index is one bit wider than the address so N = 2^ADDR_WIDTH ends without wrapping.
  assign last_word  = ({{(32-IDX_W){1'b0}}, idx_q} + 32'd1) == {{(32-HDR_N_W){1'b0}}, n_q};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    sr_d       = sr_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (Start) begin
          state_d    = StHdrHi;
          done_d     = 1'b0;
          err_d      = 1'b0;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end
      StHdrHi: begin
        if (accept) begin
          n_d[HDR_N_W-1:8] = Byte_In;
          state_d          = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          n_d = n_full;
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (n_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ Byte_In;
`endif
          byte_cnt_d = byte_cnt_q + 1'b1;
          sr_d       = {sr_q[15:0], Byte_In};
          if (byte_cnt_q == LAST_BYTE) begin
            we_d    = 1'b1;
            wdata_d = INSTR_WIDTH'({sr_q, Byte_In});
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            idx_d   = idx_q + 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StDone;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
      StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          if (Byte_In == xor_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
`else
        state_d = StErr;
        err_d   = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      n_q        <= '0;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      sr_q       <= sr_d;
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign IMEM_WE    = we_q;
  assign IMEM_Addr  = addr_q;
  assign IMEM_WData = wdata_q;
  assign CPU_Hold   = (state_q != StDone);
  assign Load_Done  = done_q;
  assign Load_Err   = err_q;

endmodule
